// File: rtl/bvshl_skolem_pkg.sv
// ============================================================================
// Package : bvshl_skolem_pkg
// Brief   : Shared types and the clipped logical-shift helper for the
//           (a << s) == t Skolem witness generator.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package bvshl_skolem_pkg;

    typedef enum logic {
        SOLVE_S = 1'b0,
        SOLVE_A = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam int c_MAXW = 64;

    // Zero-filling left shift of a w-bit value carried in a c_MAXW container;
    // any shift of w or more yields 0.
    function automatic logic [c_MAXW-1:0] shl_clip(
        input logic [c_MAXW-1:0] a,
        input int unsigned       s,
        input int unsigned       w
    );
        logic [c_MAXW-1:0] mask;
        mask = (w >= c_MAXW) ? '1 : ((c_MAXW'(1) << w) - c_MAXW'(1));
        shl_clip = (s >= w) ? '0 : ((a << s) & mask);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bvshl_eq_check.sv
// ============================================================================
// Module  : bvshl_eq_check
// Brief   : Combinational lane: hit = ((a << s) == t) with shifts >= W giving 0.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module bvshl_eq_check
    import bvshl_skolem_pkg::*;
#(
    parameter int W   = 8,
    parameter int SWC = 4
)(
    input  logic [W-1:0]   a,
    input  logic [SWC-1:0] s,
    input  logic [W-1:0]   t,
    output logic           hit
);

    logic [c_MAXW-1:0] w_shifted;

    assign w_shifted = shl_clip(c_MAXW'(a), 32'(s), W);
    assign hit       = (w_shifted == c_MAXW'(t));

endmodule

`default_nettype wire

// File: rtl/bvshl_eq_skolem_seq.sv
// ============================================================================
// Module  : bvshl_eq_skolem_seq
// Brief   : Sequential Skolem witness generator for (a << s) == t; searches s
//           LANES candidates per cycle, or solves a in closed form.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module bvshl_eq_skolem_seq
    import bvshl_skolem_pkg::*;
#(
    parameter  int W     = 8,
    parameter  int LANES = 1,
    localparam int SW    = $clog2(W + 1)
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          in_mode,
    input  logic [W-1:0]  in_a,
    input  logic [SW-1:0] in_s,
    input  logic [W-1:0]  in_t,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_sat,
    output logic [W-1:0]  out_a,
    output logic [SW-1:0] out_s,
    output logic [SW-1:0] out_iters
);

    localparam int c_GL        = (W + LANES) / LANES - 1;
    localparam int c_ITERS_MAX = (1 << SW) - 1;
    localparam int c_CW        = SW + 3;

    state_e          r_state, w_state_nxt;
    logic [W-1:0]    r_a, r_t;
    logic [SW-1:0]   r_s, r_g;
    logic            r_out_valid, r_out_sat;
    logic [W-1:0]    r_out_a;
    logic [SW-1:0]   r_out_s, r_out_iters;

    logic [LANES-1:0] w_chk, w_hit;
    logic [c_CW-1:0]  w_cand [LANES];
    logic             w_any, w_last, w_accept;
    logic [SW-1:0]    w_sel_s, w_iters, w_se;
    logic [SW:0]      w_gp1;
    logic [W-1:0]     w_sa_a;
    logic             w_sa_sat;

    generate
        for (genvar k = 0; k < LANES; k++) begin : g_lane
            assign w_cand[k] = c_CW'(r_g) * c_CW'(LANES) + c_CW'(k);
            bvshl_eq_check #(.W(W), .SWC(c_CW)) u_chk (
                .a   (r_a),
                .s   (w_cand[k]),
                .t   (r_t),
                .hit (w_chk[k])
            );
            // Candidates past W belong to no real shift amount.
            assign w_hit[k] = w_chk[k] & (w_cand[k] <= c_CW'(W));
        end
    endgenerate

    always_comb begin
        w_any   = 1'b0;
        w_sel_s = '0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (w_hit[k]) begin
                w_any   = 1'b1;
                w_sel_s = SW'(w_cand[k]);
            end
        end
    end

    assign w_last  = (r_g == SW'(c_GL));
    assign w_gp1   = {1'b0, r_g} + (SW+1)'(1);
    assign w_iters = (w_gp1 > (SW+1)'(c_ITERS_MAX)) ? '1 : w_gp1[SW-1:0];

    assign w_se     = (r_s > SW'(W)) ? SW'(W) : r_s;
    assign w_sa_a   = r_t >> w_se;
    assign w_sa_sat = ((r_t & ~({W{1'b1}} << w_se)) == '0);

    assign in_ready = (r_state == IDLE);
    assign w_accept = in_valid & in_ready;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept)
                         w_state_nxt = (mode_e'(in_mode) == SOLVE_A) ? DONE : SEARCH;
            SEARCH:  if (w_any || w_last) w_state_nxt = DONE;
            DONE:    if (r_out_valid && out_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_t         <= '0;
            r_s         <= '0;
            r_g         <= '0;
            r_out_valid <= 1'b0;
            r_out_sat   <= 1'b0;
            r_out_a     <= '0;
            r_out_s     <= '0;
            r_out_iters <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a <= in_a;
                        r_t <= in_t;
                        r_s <= in_s;
                        r_g <= '0;
                    end
                end
                SEARCH: begin
                    if (w_any || w_last) begin
                        r_out_valid <= 1'b1;
                        r_out_sat   <= w_any;
                        r_out_s     <= w_any ? w_sel_s : '0;
                        r_out_a     <= '0;
                        r_out_iters <= w_iters;
                    end else begin
                        r_g <= r_g + SW'(1);
                    end
                end
                DONE: begin
                    // DONE without a valid result only follows a SOLVE_A accept.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_out_sat   <= w_sa_sat;
                        r_out_a     <= w_sa_a;
                        r_out_s     <= '0;
                        r_out_iters <= '0;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_valid = r_out_valid;
    assign out_sat   = r_out_sat;
    assign out_a     = r_out_a;
    assign out_s     = r_out_s;
    assign out_iters = r_out_iters;

endmodule

`default_nettype wire

// File: tb/tb_bvshl_eq_skolem_seq.sv
// ============================================================================
// Module  : tb_bvshl_eq_skolem_seq
// Brief   : Self-checking bench; W=8 instances at LANES=1,2,4.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bvshl_eq_skolem_seq;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0]       in_valid, in_ready, in_mode, out_valid, out_ready, out_sat;
    logic [2:0][7:0]  in_a, in_t, out_a;
    logic [2:0][3:0]  in_s, out_s, out_iters;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    generate
        for (genvar i = 0; i < 3; i++) begin : g_dut
            bvshl_eq_skolem_seq #(.W(8), .LANES(1 << i)) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (in_valid[i]),
                .in_ready  (in_ready[i]),
                .in_mode   (in_mode[i]),
                .in_a      (in_a[i]),
                .in_s      (in_s[i]),
                .in_t      (in_t[i]),
                .out_valid (out_valid[i]),
                .out_ready (out_ready[i]),
                .out_sat   (out_sat[i]),
                .out_a     (out_a[i]),
                .out_s     (out_s[i]),
                .out_iters (out_iters[i])
            );
        end
    endgenerate

    typedef struct {
        int d; int mode; int a; int s; int t; int hold;
        int e_sat; int e_a; int e_s; int e_it; int e_lat;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: brute-force the minimal shift, or divide out the shift.
    task automatic model(input int lanes, input int mode, input int a, input int s,
                         input int t, output int sat, output int oa, output int os,
                         output int it, output int lat);
        int se;
        sat = 0; oa = 0; os = 0; it = 0; lat = 1;
        if (mode == 0) begin
            for (int k = 0; k <= 8; k++)
                if (sat == 0 && ((a * (1 << k)) % 256) == t) begin
                    sat = 1;
                    os  = k;
                end
            it  = (sat != 0) ? (os / lanes + 1) : ((9 + lanes - 1) / lanes);
            lat = it;
        end else begin
            se  = (s > 8) ? 8 : s;
            oa  = t / (1 << se);
            sat = ((t % (1 << se)) == 0) ? 1 : 0;
        end
    endtask

    task automatic run_txn(input int d, input int mode, input int a, input int s,
                           input int t, input int hold, output int sat, output int oa,
                           output int os, output int it, output int lat);
        logic [20:0] snap;
        chk("in_ready_idle", int'(in_ready[d]), 1);
        in_mode[d]  = mode[0];
        in_a[d]     = 8'(a);
        in_s[d]     = 4'(s);
        in_t[d]     = 8'(t);
        in_valid[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[d] = 1'b0;
        lat = 0;
        while (!out_valid[d] && lat < 200) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        sat = int'(out_sat[d]);
        oa  = int'(out_a[d]);
        os  = int'(out_s[d]);
        it  = int'(out_iters[d]);
        snap = {out_valid[d], out_sat[d], out_a[d], out_s[d], out_iters[d]};
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            chk("hold_stable", int'({out_valid[d], out_sat[d], out_a[d], out_s[d], out_iters[d]}),
                int'(snap));
            chk("hold_in_ready", int'(in_ready[d]), 0);
        end
        out_ready[d] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[d] = 1'b0;
        chk("valid_drop", int'(out_valid[d]), 0);
        chk("in_ready_back", int'(in_ready[d]), 1);
    endtask

    vec_t vecs[$];

    initial begin
        int sat, oa, os, it, lat;
        int e_sat, e_a, e_s, e_it, e_lat;
        int seen;
        vec_t v;

        vecs.push_back('{0, 0, 8'h03, 0, 8'h18, 5, 1, 0, 3, 4, 4});
        vecs.push_back('{0, 0, 8'h03, 0, 8'h05, 0, 0, 0, 0, 9, 9});
        vecs.push_back('{0, 0, 8'h81, 0, 8'h00, 0, 1, 0, 8, 9, 9});
        vecs.push_back('{0, 0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 1, 1});
        vecs.push_back('{2, 0, 8'h01, 0, 8'h40, 0, 1, 0, 6, 2, 2});
        vecs.push_back('{1, 0, 8'h01, 0, 8'h40, 0, 1, 0, 6, 4, 4});
        vecs.push_back('{2, 0, 8'h81, 0, 8'h00, 0, 1, 0, 8, 3, 3});
        vecs.push_back('{0, 1, 0, 2, 8'h14, 0, 1, 8'h05, 0, 0, 1});
        vecs.push_back('{0, 1, 0, 2, 8'h15, 0, 0, 8'h05, 0, 0, 1});
        vecs.push_back('{0, 1, 0, 9, 8'h00, 0, 1, 0, 0, 0, 1});
        vecs.push_back('{0, 1, 0, 8, 8'h01, 0, 0, 0, 0, 0, 1});
        vecs.push_back('{2, 1, 0, 15, 8'h80, 3, 0, 0, 0, 0, 1});

        rst_n = 1'b0;
        in_valid = '0; in_mode = '0; out_ready = '0;
        in_a = '0; in_s = '0; in_t = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_out_valid", int'(out_valid[i]), 0);
            chk("rst_in_ready", int'(in_ready[i]), 1);
            chk("rst_outs", int'({out_sat[i], out_a[i], out_s[i], out_iters[i]}), 0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            run_txn(v.d, v.mode, v.a, v.s, v.t, v.hold, sat, oa, os, it, lat);
            chk($sformatf("vec%0d_sat", i), sat, v.e_sat);
            chk($sformatf("vec%0d_a", i), oa, v.e_a);
            chk($sformatf("vec%0d_s", i), os, v.e_s);
            chk($sformatf("vec%0d_iters", i), it, v.e_it);
            chk($sformatf("vec%0d_latency", i), lat, v.e_lat);
        end

        // Reset while lane-1 instance is in group 2 of an unsat search.
        in_mode[0] = 1'b0; in_a[0] = 8'h03; in_t[0] = 8'h05; in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort_in_ready", int'(in_ready[0]), 1);
        chk("abort_out_valid", int'(out_valid[0]), 0);
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid[0]) seen++;
        end
        chk("abort_no_emit", seen, 0);
        run_txn(0, 0, 8'h03, 0, 8'h18, 0, sat, oa, os, it, lat);
        chk("post_abort_s", os, 3);
        chk("post_abort_iters", it, 4);
        chk("post_abort_latency", lat, 4);

        for (int r = 0; r < 40; r++) begin
            int d, mode, a, s, t;
            d    = int'($urandom_range(0, 2));
            mode = int'($urandom_range(0, 1));
            a    = int'($urandom_range(0, 255));
            s    = int'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1)
                t = (a * (1 << $urandom_range(0, 9))) % 256;
            else
                t = int'($urandom_range(0, 255));
            run_txn(d, mode, a, s, t, int'($urandom_range(0, 2)), sat, oa, os, it, lat);
            model(1 << d, mode, a, s, t, e_sat, e_a, e_s, e_it, e_lat);
            chk("rnd_result", {sat, oa, os, it}, {e_sat, e_a, e_s, e_it});
            chk("rnd_latency", lat, e_lat);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
